// File: rtl/instr_fetch_stage_pkg.sv
// fetch_pkg: shared constants, FSM encoding and entry type for the instruction-fetch stage.
package fetch_pkg;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] KILL = 2'd2;
    localparam logic [1:0] FULL = 2'd3;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction-memory req/ack fetch bus.
interface instr_fetch_stage_if;
    import fetch_pkg::*;
    logic               imem_req_o;
    logic [31:0]        imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_data_i;

    modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_data_i);
    modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_data_i);
endinterface

// File: rtl/instr_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, load beats hold, unheld entries are consumed.
module if_id_reg import fetch_pkg::*; (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         load,
    input  logic         hold,
    input  fetch_entry_t entry_d,
    output logic         valid,
    output fetch_entry_t entry
);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= entry_d;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC/fetch FSM with one-entry skid buffer feeding the IF/ID register.
module instr_fetch_stage import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk_i,
    input  logic                rst_i,
    instr_fetch_stage_if.master imem,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                valid_o,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         pc_plus4_o,
    output logic [15:0]         imm16_o
);
    logic [1:0]   state, state_d;
    logic [31:0]  fetch_pc, kill_addr;
    logic         slot_free, ack, load;
    fetch_entry_t skid, entry_d, if_id;

    assign slot_free        = !valid_o || !stall_i;
    assign imem.imem_req_o  = state == REQ || state == KILL;
    assign ack              = imem.imem_req_o && imem.imem_ack_i;
    // KILL keeps presenting the abandoned address until its ack retires it
    assign imem.imem_addr_o = state == KILL ? kill_addr : fetch_pc;
    assign load             = slot_free && ((state == REQ && ack) || state == FULL);
    assign entry_d.instr    = state == FULL ? skid.instr : imem.imem_data_i;
    assign entry_d.pc       = state == FULL ? skid.pc : fetch_pc;

    always_comb begin
        state_d = redirect_i      ? (imem.imem_req_o && !ack ? KILL : REQ)
                : state == IDLE   ? REQ
                : state == REQ    ? (ack && !slot_free ? FULL : REQ)
                : state == FULL   ? (slot_free ? REQ : FULL)
                :                   (ack ? REQ : KILL);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            kill_addr <= RESET_PC;
            skid      <= '0;
        end else begin
            state     <= state_d;
            kill_addr <= state == REQ ? fetch_pc : kill_addr;
            fetch_pc  <= redirect_i ? word_align(redirect_pc_i)
                       : (state == REQ && ack) ? fetch_pc + PC_INC : fetch_pc;
            if (state == REQ && ack && !slot_free) begin
                skid.instr <= imem.imem_data_i;
                skid.pc    <= fetch_pc;
            end
        end
    end

    if_id_reg u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (redirect_i),
        .load    (load),
        .hold    (stall_i),
        .entry_d (entry_d),
        .valid   (valid_o),
        .entry   (if_id)
    );

    assign instr_o    = if_id.instr;
    assign pc_o       = if_id.pc;
    assign pc_plus4_o = pc_o + PC_INC;
    assign imm16_o    = instr_o[15:0];
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed and random fetch traffic against a program-order scoreboard.
module tb_instr_fetch_stage;
    localparam logic [31:0] C   = 32'hA5A5_0000;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1, rst2_n = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid, valid2;
    logic [31:0] instr, pc, pc4, instr2, pc2, pc4_2;
    logic [15:0] imm16, imm16_2;

    instr_fetch_stage_if bus();
    instr_fetch_stage_if bus2();

    instr_fetch_stage dut (
        .clk_i(clk), .rst_i(rst_n), .imem(bus), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .valid_o(valid), .instr_o(instr), .pc_o(pc),
        .pc_plus4_o(pc4), .imm16_o(imm16)
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk_i(clk), .rst_i(rst2_n), .imem(bus2), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .valid_o(valid2), .instr_o(instr2), .pc_o(pc2),
        .pc_plus4_o(pc4_2), .imm16_o(imm16_2)
    );

    // zero-wait memory for the wrap-around instance
    assign bus2.imem_ack_i  = bus2.imem_req_o;
    assign bus2.imem_data_i = bus2.imem_addr_o ^ C;

    int          n_cmp = 0, n_bad = 0, ndel = 0, n0;
    logic [31:0] exp_pc = '0, held_addr = '0, a;
    logic        held = 1'b0, rnd = 1'b0;
    int          cnt = 0, lat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, answer memory, score delivered instructions, clock.
    task automatic tick(input logic s, input logic r, input logic [31:0] t);
        logic [31:0] e;
        stall = s; redirect = r; redirect_pc = t;
        if (bus.imem_req_o) begin
            if (held) chk("addr_hold", bus.imem_addr_o, held_addr);
            bus.imem_ack_i  = cnt >= lat;
            bus.imem_data_i = bus.imem_ack_i ? bus.imem_addr_o ^ C : BAD;
        end else begin
            bus.imem_ack_i  = 1'b0;
            bus.imem_data_i = BAD;
        end
        if (valid) begin
            e = pc ^ C;
            chk("instr", instr, e);
            chk("imm16", {16'h0, imm16}, {16'h0, e[15:0]});
            chk("pc_plus4", pc4, pc + 32'd4);
            if (!s) begin
                chk("pc_seq", pc, exp_pc);
                exp_pc += 32'd4;
                ndel++;
            end
        end
        if (r) exp_pc = {t[31:2], 2'b00};
        if (bus.imem_req_o) begin
            if (bus.imem_ack_i) begin
                held = 1'b0; cnt = 0;
                if (rnd) lat = $urandom_range(0, 2);
            end else begin
                held = 1'b1; held_addr = bus.imem_addr_o; cnt++;
            end
        end
        @(posedge clk); #1;
        if (r) chk("flush_valid", {31'h0, valid}, 32'h0);
        @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk);
        bus.imem_ack_i = 1'b0; rst_n = 1'b1;
        exp_pc = '0; held = 1'b0; cnt = 0; lat = 0;
        chk("restart_idle_req", {31'h0, bus.imem_req_o}, 32'h0);
        tick(0, 0, 0);
        chk("restart_req", {31'h0, bus.imem_req_o}, 32'h1);
        chk("restart_addr", bus.imem_addr_o, 32'h0);
        tick(0, 0, 0);
        chk("restart_valid", {31'h0, valid}, 32'h1);
        chk("restart_pc", pc, 32'h0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0; bus.imem_ack_i = 1'b1; bus.imem_data_i = BAD;
        #1;
        chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
        chk({tag, "_req"}, {31'h0, bus.imem_req_o}, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_req_held"}, {31'h0, bus.imem_req_o}, 32'h0);
        restart();
    endtask

    initial begin
        bus.imem_ack_i = 1'b0; bus.imem_data_i = BAD;
        #1 rst_n = 1'b0; rst2_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'h0, bus.imem_req_o}, 32'h0);
        chk("rst_imm16", {16'h0, imm16}, 32'h0);
        chk("rst_pc_plus4", pc4, 32'h4);

        // zero-wait stream
        rst_n = 1'b1;
        chk("first_idle", {31'h0, bus.imem_req_o}, 32'h0);
        tick(0, 0, 0);
        chk("first_req", {31'h0, bus.imem_req_o}, 32'h1);
        chk("addr0", bus.imem_addr_o, 32'h0);
        tick(0, 0, 0);
        chk("first_valid", {31'h0, valid}, 32'h1);
        chk("first_instr", instr, 32'hA5A5_0000);
        chk("addr4", bus.imem_addr_o, 32'h4);
        tick(0, 0, 0);
        chk("second_instr", instr, 32'hA5A5_0004);
        chk("second_imm16", {16'h0, imm16}, 32'h0004);
        chk("addr8", bus.imem_addr_o, 32'h8);

        // stall fills the skid buffer and drops the request
        tick(1, 0, 0);
        chk("full_req", {31'h0, bus.imem_req_o}, 32'h0);
        chk("full_pc", pc, 32'h4);
        tick(1, 0, 0);
        chk("full_req2", {31'h0, bus.imem_req_o}, 32'h0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        chk("skid_pc", pc, 32'h8);
        chk("skid_next_addr", bus.imem_addr_o, 32'hC);
        repeat (3) tick(0, 0, 0);

        // redirect during a 2-cycle wait
        a = bus.imem_addr_o; lat = 2;
        tick(0, 1, 32'h0000_0103);
        chk("kill_req", {31'h0, bus.imem_req_o}, 32'h1);
        chk("kill_addr", bus.imem_addr_o, a);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("kill_done_addr", bus.imem_addr_o, 32'h100);
        chk("kill_done_valid", {31'h0, valid}, 32'h0);
        for (int i = 0; i < 8 && !valid; i++) tick(0, 0, 0);
        chk("redir_valid", {31'h0, valid}, 32'h1);
        chk("redir_pc", pc, 32'h100);

        // redirect coincident with ack, then redirect in FULL under stall
        lat = 0;
        tick(0, 0, 0);
        tick(0, 1, 32'h200);
        chk("ack_redir_req", {31'h0, bus.imem_req_o}, 32'h1);
        chk("ack_redir_addr", bus.imem_addr_o, 32'h200);
        tick(0, 0, 0);
        chk("ack_redir_pc", pc, 32'h200);
        tick(1, 0, 0);
        chk("full2_req", {31'h0, bus.imem_req_o}, 32'h0);
        tick(1, 1, 32'h300);
        chk("full_redir_req", {31'h0, bus.imem_req_o}, 32'h1);
        chk("full_redir_addr", bus.imem_addr_o, 32'h300);
        tick(0, 0, 0);
        chk("full_redir_pc", pc, 32'h300);

        // random traffic
        n0 = ndel; rnd = 1'b1;
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom);
        rnd = 1'b0; lat = 0;
        repeat (6) tick(0, 0, 0);
        chk("progress", {31'h0, (ndel - n0) >= 40}, 32'h1);

        // async reset mid-request and in KILL
        lat = 2;
        tick(1, 0, 0);
        chk("pre_rst_valid", {31'h0, valid}, 32'h1);
        async_reset("rst_req");
        lat = 2;
        tick(0, 1, 32'h500);
        chk("pre_rst_kill_req", {31'h0, bus.imem_req_o}, 32'h1);
        async_reset("rst_kill");

        // wrap-around at the top of the address space
        rst2_n = 1'b1;
        for (int i = 0; i < 6 && !valid2; i++) @(negedge clk);
        chk("wrap_valid", {31'h0, valid2}, 32'h1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        chk("wrap_instr0", instr2, 32'hFFFF_FFF8 ^ C);
        @(negedge clk);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc4_2, 32'h0);
        @(negedge clk);
        chk("wrap_pc2", pc2, 32'h0);
        chk("wrap_instr2", instr2, C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
